writeback_stage: RTL
====================

# writeback_stage

Writeback stage of the pipelined processor, sitting directly upstream of the register file and driving its single write port (`ctrl_writeEnable`, `ctrl_writeReg`, `data_writeReg`). Arbitrates between the in-order main pipeline result and out-of-order multiply/divide results, buffering the latter in a 2-entry FIFO. Maintains a 32-bit busy scoreboard of registers awaiting a multdiv result, which the hazard unit consumes.

## Interface
- `FIFO_DEPTH`, 2: multdiv result buffer entries; only 2 is supported.
- `clock`  in  1  sole clock; all state updates on rising edge.
- `ctrl_reset`  in  1  synchronous, active-low reset; state clears on a rising edge where `ctrl_reset`=0.
- `wb_valid`  in  1  main pipeline has a result this cycle.
- `wb_reg`  in  5  main pipeline destination register.
- `wb_data`  in  32  main pipeline result.
- `md_valid`  in  1  multdiv unit offers a result.
- `md_reg`  in  5  multdiv destination register.
- `md_data`  in  32  multdiv result.
- `md_ready`  out  1  stage can accept a multdiv result this cycle.
- `md_issue`  in  1  execute stage is issuing a multdiv op this cycle.
- `md_issue_reg`  in  5  destination register of the issuing op.
- `ctrl_writeEnable`  out  1  register-file write enable (registered).
- `ctrl_writeReg`  out  5  register-file write index (registered).
- `data_writeReg`  out  32  register-file write data (registered).
- `md_busy`  out  32  scoreboard; bit i=1 means register i awaits a multdiv writeback (registered).

## Operation
- A main write is valid when `wb_valid`=1 and `wb_reg`≠0. A write with `wb_reg`=0 is dropped and does not occupy the write port.
- Multdiv handshake: a result is accepted on an edge where `md_valid`=1 and `md_ready`=1.
- `md_ready`=1 iff FIFO count<2 and `ctrl_reset`=1. It depends only on the registered count, not on the same-cycle pop.
- Per-cycle arbitration, evaluated in priority order:
  1. A valid main write loads the output register. The FIFO does not pop. An accepted multdiv result is pushed.
  2. Otherwise, if the FIFO is non-empty, the head is popped into the output register. An accepted multdiv result is pushed in the same cycle; count is unchanged.
  3. Otherwise, if the FIFO is empty and a multdiv result is accepted, it bypasses the FIFO straight into the output register.
  4. Otherwise `ctrl_writeEnable` goes to 0 on the next edge. `ctrl_writeReg` and `data_writeReg` hold their values.
- An accepted multdiv result with `md_reg`=0 is discarded: it is not pushed, not written, and the scoreboard is unaffected.
- The FIFO preserves multdiv arrival order. Pointers are 1 bit each and wrap modulo 2.
- Scoreboard:
  - `md_issue` with `md_issue_reg`≠0 sets bit `md_issue_reg`.
  - Bit r clears on the edge where a multdiv result for r loads the output register.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
  - Bit 0 is always 0.
- The main pipeline is never stalled by this block. Main-versus-multdiv WAW ordering is the hazard unit's responsibility, enforced via `md_busy`.

## Timing
- Latency is 1 cycle from an input (main write or bypassed multdiv) to `ctrl_writeEnable`/`ctrl_writeReg`/`data_writeReg`. The register file commits on the following edge.
- A buffered multdiv result waits one cycle plus one cycle per consecutive valid main write.
- Reset: takes effect on any edge with `ctrl_reset`=0, including mid-operation.
  - Clears to 0: `ctrl_writeEnable`, `ctrl_writeReg`, `data_writeReg`, `md_busy`, FIFO count, and FIFO pointers.
  - Buffered results are lost.
  - `md_ready`=0 while reset is asserted and 1 on the first cycle after release.
- Full FIFO: with count=2, `md_ready`=0. The multdiv unit must hold `md_valid` and its data until acceptance.
- `md_busy` updates one edge after `md_issue`, so the hazard unit sees the bit on the cycle after issue.

## Test plan
- Reset: drive `ctrl_reset`=0 for 2 cycles with random inputs -> all outputs 0, `md_ready`=0. After release, `md_ready`=1.
- Bypass: FIFO empty, no main write, `md_valid`=1 with `md_reg`=5 and `md_data`=0x12345678 -> next cycle `ctrl_writeEnable`=1, `ctrl_writeReg`=5, `data_writeReg`=0x12345678. `md_busy[5]` clears on that same edge.
- Contention: `wb_valid`=1 for 4 cycles (regs 1–4) while multdiv offers regs 6, 7, 8 back-to-back -> regs 1–4 are written in order. `md_ready` drops after 6 and 7 are buffered; 8 is held. Afterwards 6, 7, 8 are written on consecutive cycles.
- r0 filtering: `wb_valid`=1 with `wb_reg`=0 while the FIFO holds reg 9 -> reg 9 is written next cycle. Multdiv result to r0 -> no write, count unchanged.
- Scoreboard race: bit 10 set, multdiv result for 10 loads the output while `md_issue`=1 with `md_issue_reg`=10 -> `md_busy[10]` remains 1.
- Mid-operation reset: FIFO full, then `ctrl_reset`=0 for 1 cycle -> count 0, no writes of stale data after release, `md_busy`=0.

Source files
------------

// File: rtl/writeback_stage_if.sv
// ---------------------------------------------------------------------------
// writeback_stage_if
//   Bundles the writeback stage's pipeline-facing and register-file-facing
//   signals.
//   slave  : the writeback stage itself (consumes results, drives write port)
//   master : the surrounding pipeline / testbench (offers results)
//   Signals:
//     wb_valid/wb_reg/wb_data           main pipeline result
//     md_valid/md_reg/md_data/md_ready  multdiv result handshake
//     md_issue/md_issue_reg             multdiv op issue (scoreboard set)
//     ctrl_writeEnable/ctrl_writeReg/data_writeReg  register-file write port
//     md_busy                           scoreboard of pending multdiv dests
// ---------------------------------------------------------------------------
interface writeback_stage_if;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        md_valid;
    logic [4:0]  md_reg;
    logic [31:0] md_data;
    logic        md_ready;
    logic        md_issue;
    logic [4:0]  md_issue_reg;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic [31:0] md_busy;

    modport slave (
        input  wb_valid, wb_reg, wb_data,
        input  md_valid, md_reg, md_data,
        output md_ready,
        input  md_issue, md_issue_reg,
        output ctrl_writeEnable, ctrl_writeReg, data_writeReg,
        output md_busy
    );

    modport master (
        output wb_valid, wb_reg, wb_data,
        output md_valid, md_reg, md_data,
        input  md_ready,
        output md_issue, md_issue_reg,
        input  ctrl_writeEnable, ctrl_writeReg, data_writeReg,
        input  md_busy
    );
endinterface

// File: rtl/writeback_stage.sv
// ---------------------------------------------------------------------------
// writeback_stage
//   Drives the register file's single write port. Main pipeline results have
//   priority; multdiv results are written when the port is free, buffered in
//   a 2-entry FIFO otherwise. Keeps a busy scoreboard of registers that still
//   await a multdiv result.
//   Ports:
//     clock       rising-edge clock
//     ctrl_reset  synchronous active-low reset
//     bus         writeback_stage_if.slave (see interface header)
// ---------------------------------------------------------------------------
module writeback_stage #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic               clock,
    input  logic               ctrl_reset,
    writeback_stage_if.slave   bus
);
    localparam logic [1:0] DEPTH = 2'(FIFO_DEPTH);

    // FIFO storage and control
    logic [4:0]  fifo_reg_q  [2];
    logic [31:0] fifo_data_q [2];
    logic [1:0]  count_q, count_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;

    // Output and scoreboard registers
    logic        we_q, we_d;
    logic [4:0]  wreg_q, wreg_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] busy_q;

    logic        main_ok;
    logic        md_acc;
    logic        md_keep;
    logic        push;
    logic        pop;
    logic [31:0] set_vec;
    logic [31:0] clr_vec;

    // Ready depends only on the registered count, never on a same-cycle pop.
    assign bus.md_ready = (count_q < DEPTH) && ctrl_reset;

    assign main_ok = bus.wb_valid && (bus.wb_reg != 5'd0);
    assign md_acc  = bus.md_valid && bus.md_ready;
    // Results for r0 complete the handshake but are otherwise discarded.
    assign md_keep = md_acc && (bus.md_reg != 5'd0);

    always_comb begin
        we_d    = 1'b0;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        push    = 1'b0;
        pop     = 1'b0;
        clr_vec = '0;
        if (main_ok) begin
            we_d    = 1'b1;
            wreg_d  = bus.wb_reg;
            wdata_d = bus.wb_data;
            push    = md_keep;
        end else if (count_q != 2'd0) begin
            we_d    = 1'b1;
            wreg_d  = fifo_reg_q[rd_ptr_q];
            wdata_d = fifo_data_q[rd_ptr_q];
            pop     = 1'b1;
            push    = md_keep;
            clr_vec[fifo_reg_q[rd_ptr_q]] = 1'b1;
        end else if (md_keep) begin
            // Empty FIFO and free port: bypass straight to the write port.
            we_d    = 1'b1;
            wreg_d  = bus.md_reg;
            wdata_d = bus.md_data;
            clr_vec[bus.md_reg] = 1'b1;
        end
    end

    always_comb begin
        set_vec = '0;
        if (bus.md_issue && (bus.md_issue_reg != 5'd0)) begin
            set_vec[bus.md_issue_reg] = 1'b1;
        end
    end

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!ctrl_reset) begin
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            we_q     <= 1'b0;
            wreg_q   <= 5'd0;
            wdata_q  <= 32'd0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            we_q     <= we_d;
            wreg_q   <= wreg_d;
            wdata_q  <= wdata_d;
        end
    end

    // FIFO entries: payload only, no reset needed since count guards reads.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge clock) begin
                if (push && (wr_ptr_q == 1'(gi))) begin
                    fifo_reg_q[gi]  <= bus.md_reg;
                    fifo_data_q[gi] <= bus.md_data;
                end
            end
        end
    endgenerate

    // Scoreboard: a set on the same edge as a clear wins; bit 0 stays 0.
    always_ff @(posedge clock) begin
        busy_q[0] <= 1'b0;
    end

    generate
        for (gi = 1; gi < 32; gi++) begin : g_busy
            always_ff @(posedge clock) begin
                if (!ctrl_reset) begin
                    busy_q[gi] <= 1'b0;
                end else if (set_vec[gi]) begin
                    busy_q[gi] <= 1'b1;
                end else if (clr_vec[gi]) begin
                    busy_q[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    assign bus.ctrl_writeEnable = we_q;
    assign bus.ctrl_writeReg    = wreg_q;
    assign bus.data_writeReg    = wdata_q;
    assign bus.md_busy          = busy_q;
endmodule
